// File: rtl/sim_pkg.sv
// Shared constants and state encoding for the node frame streamer.
package sim_pkg;
    localparam int FRAC_BITS = 16;
    localparam int SCREEN_W  = 640;
    localparam int SCREEN_H  = 480;
    localparam int PIX_W     = 10;

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;
endpackage

// File: rtl/pix_clamp.sv
// Combinational Q16.16 -> pixel conversion with clamp to [0, LIMIT-1].
module pix_clamp
    import sim_pkg::*;
#(
    parameter int LIMIT = SCREEN_W
) (
    input  logic [31:0]      coord,
    output logic [PIX_W-1:0] pix,
    output logic             clip
);
    localparam logic signed [31:0] MAX_V = 32'(LIMIT - 1);

    // Arithmetic shift floors toward -inf, so -0.5 lands on -1 and clamps.
    logic signed [31:0] ipart;
    assign ipart = $signed(coord) >>> FRAC_BITS;

    // Clamp the integer part into the visible range and flag any clamping.
    always_comb begin
        pix  = ipart[PIX_W-1:0];
        clip = 1'b0;
        if (ipart < 0) begin
            pix  = '0;
            clip = 1'b1;
        end else if (ipart > MAX_V) begin
            pix  = MAX_V[PIX_W-1:0];
            clip = 1'b1;
        end
    end
endmodule

// File: rtl/node_frame_streamer.sv
// Snapshots node positions on frame_tick and streams one clamped (px,py)
// beat per node over valid/ready, in index order.
module node_frame_streamer
    import sim_pkg::*;
#(
    parameter int NODE_COUNT = 5,
    parameter int IDX_W      = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    frame_tick,
    input  logic [NODE_COUNT*32-1:0] nodes_x,
    input  logic [NODE_COUNT*32-1:0] nodes_y,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [PIX_W-1:0]        out_px,
    output logic [PIX_W-1:0]        out_py,
    output logic [IDX_W-1:0]        out_idx,
    output logic                    out_last,
    output logic                    out_clipped,
    output logic                    busy,
    output logic [15:0]             overrun_cnt
);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NODE_COUNT - 1);

    logic [NODE_COUNT-1:0][PIX_W-1:0] cx_px, cy_py, snap_px, snap_py;
    logic [NODE_COUNT-1:0]            cx_clip, cy_clip, snap_clip;

    genvar g;
    generate
        for (g = 0; g < NODE_COUNT; g++) begin : g_conv
            pix_clamp #(.LIMIT(SCREEN_W)) u_cx (
                .coord (nodes_x[g*32 +: 32]),
                .pix   (cx_px[g]),
                .clip  (cx_clip[g])
            );
            pix_clamp #(.LIMIT(SCREEN_H)) u_cy (
                .coord (nodes_y[g*32 +: 32]),
                .pix   (cy_py[g]),
                .clip  (cy_clip[g])
            );
        end
    endgenerate

    state_t           state, state_n;
    logic [IDX_W-1:0] idx, idx_n;
    logic             hs, capture, drop;

    assign hs        = out_valid & out_ready;
    assign out_valid = (state == STREAM);
    assign busy      = (state == STREAM);
    assign out_idx   = idx;

    // Next state / index; a tick on the final handshake chains the next frame.
    always_comb begin
        state_n = state;
        idx_n   = idx;
        capture = 1'b0;
        drop    = 1'b0;
        case (state)
            IDLE: begin
                if (frame_tick) begin
                    state_n = STREAM;
                    idx_n   = '0;
                    capture = 1'b1;
                end
            end
            STREAM: begin
                if (hs && idx == LAST_IDX) begin
                    idx_n = '0;
                    if (frame_tick) capture = 1'b1;
                    else            state_n = IDLE;
                end else begin
                    drop = frame_tick;
                    if (hs) idx_n = idx + IDX_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State, index and snapshot registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            idx       <= '0;
            snap_px   <= '0;
            snap_py   <= '0;
            snap_clip <= '0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            if (capture) begin
                snap_px   <= cx_px;
                snap_py   <= cy_py;
                snap_clip <= cx_clip | cy_clip;
            end
        end
    end

    // Beat registers: node 0 comes straight from the converters on capture,
    // later beats from the snapshot; zeroed whenever no beat is presented.
    always_ff @(posedge clk) begin
        if (!reset || state_n != STREAM) begin
            out_px      <= '0;
            out_py      <= '0;
            out_clipped <= 1'b0;
            out_last    <= 1'b0;
        end else begin
            out_last <= (idx_n == LAST_IDX);
            if (capture) begin
                out_px      <= cx_px[0];
                out_py      <= cy_py[0];
                out_clipped <= cx_clip[0] | cy_clip[0];
            end else begin
                out_px      <= snap_px[idx_n];
                out_py      <= snap_py[idx_n];
                out_clipped <= snap_clip[idx_n];
            end
        end
    end

    // Saturating count of ticks that arrive while a frame is still streaming.
    always_ff @(posedge clk) begin
        if (!reset)
            overrun_cnt <= '0;
        else if (drop && overrun_cnt != 16'hFFFF)
            overrun_cnt <= overrun_cnt + 16'd1;
    end
endmodule

// File: tb/tb_node_frame_streamer.sv
// Directed self-checking bench for node_frame_streamer.
module tb_node_frame_streamer;
    localparam int N = 5;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           frame_tick = 1'b0;
    logic [N*32-1:0] nodes_x = '0;
    logic [N*32-1:0] nodes_y = '0;
    logic           out_valid, out_ready = 1'b1;
    logic [9:0]     out_px, out_py;
    logic [2:0]     out_idx;
    logic           out_last, out_clipped, busy;
    logic [15:0]    overrun_cnt;

    int n_chk = 0;
    int n_err = 0;

    node_frame_streamer #(.NODE_COUNT(N), .IDX_W(3)) dut (
        .clk         (clk),
        .reset       (reset),
        .frame_tick  (frame_tick),
        .nodes_x     (nodes_x),
        .nodes_y     (nodes_y),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_px      (out_px),
        .out_py      (out_py),
        .out_idx     (out_idx),
        .out_last    (out_last),
        .out_clipped (out_clipped),
        .busy        (busy),
        .overrun_cnt (overrun_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ramp();
        for (int i = 0; i < N; i++) begin
            nodes_x[i*32 +: 32] = 32'(i) * 32'h000A_0000;
            nodes_y[i*32 +: 32] = 32'h0014_0000;
        end
    endtask

    task automatic chk_beat(input string tag, input int idx, input int px, input int py,
                            input logic clipped);
        chk({tag, ".valid"}, 32'(out_valid), 32'd1);
        chk({tag, ".idx"},   32'(out_idx),   32'(idx));
        chk({tag, ".px"},    32'(out_px),    32'(px));
        chk({tag, ".py"},    32'(out_py),    32'(py));
        chk({tag, ".last"},  32'(out_last),  32'(idx == N - 1));
        chk({tag, ".clip"},  32'(out_clipped), 32'(clipped));
    endtask

    task automatic start_frame();
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
    endtask

    int ex_px[N];
    int ex_py[N];
    logic ex_cl[N];

    initial begin
        // 1: reset held low for 3 cycles
        reset = 1'b0;
        repeat (3) tick();
        chk("rst.valid", 32'(out_valid), 32'd0);
        chk("rst.busy",  32'(busy), 32'd0);
        chk("rst.ovr",   32'(overrun_cnt), 32'd0);
        chk("rst.px",    32'(out_px), 32'd0);
        chk("rst.last",  32'(out_last), 32'd0);
        reset = 1'b1;
        tick();

        // 2: full-rate frame
        set_ramp();
        out_ready = 1'b1;
        start_frame();
        for (int i = 0; i < N; i++) begin
            chk_beat("t2", i, i * 10, 20, 1'b0);
            chk("t2.busy", 32'(busy), 32'd1);
            tick();
        end
        chk("t2.end_valid", 32'(out_valid), 32'd0);
        chk("t2.end_busy",  32'(busy), 32'd0);

        // 3: stall at idx 2; bus changes during the stall must not leak in
        start_frame();
        chk_beat("t3.b0", 0, 0, 20, 1'b0);
        tick();
        chk_beat("t3.b1", 1, 10, 20, 1'b0);
        tick();
        out_ready = 1'b0;
        nodes_x = '0;
        nodes_y = '0;
        for (int s = 0; s < 3; s++) begin
            chk_beat("t3.hold", 2, 20, 20, 1'b0);
            tick();
        end
        out_ready = 1'b1;
        chk_beat("t3.b2", 2, 20, 20, 1'b0);
        tick();
        chk_beat("t3.b3", 3, 30, 20, 1'b0);
        tick();
        chk_beat("t3.b4", 4, 40, 20, 1'b0);
        tick();
        chk("t3.end_valid", 32'(out_valid), 32'd0);

        // 4: clipping
        nodes_x[0*32 +: 32] = 32'hFFFF_0000; nodes_y[0*32 +: 32] = 32'h0005_0000;
        nodes_x[1*32 +: 32] = 32'h0300_0000; nodes_y[1*32 +: 32] = 32'h0005_0000;
        nodes_x[2*32 +: 32] = 32'h0000_0000; nodes_y[2*32 +: 32] = 32'h01E0_0000;
        nodes_x[3*32 +: 32] = 32'h0000_FFFF; nodes_y[3*32 +: 32] = 32'h0005_0000;
        nodes_x[4*32 +: 32] = 32'h0064_0000; nodes_y[4*32 +: 32] = 32'h00C8_0000;
        ex_px = '{0, 639, 0, 0, 100};
        ex_py = '{5, 5, 479, 5, 200};
        ex_cl = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        start_frame();
        for (int i = 0; i < N; i++) begin
            chk_beat("t4", i, ex_px[i], ex_py[i], ex_cl[i]);
            tick();
        end
        chk("t4.end_valid", 32'(out_valid), 32'd0);

        // 5: dropped tick mid-stream, then back-to-back frame on the last handshake
        set_ramp();
        start_frame();
        tick();
        chk_beat("t5.b1", 1, 10, 20, 1'b0);
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
        chk("t5.ovr", 32'(overrun_cnt), 32'd1);
        chk_beat("t5.b2", 2, 20, 20, 1'b0);
        tick();
        chk_beat("t5.b3", 3, 30, 20, 1'b0);
        tick();
        chk_beat("t5.b4", 4, 40, 20, 1'b0);
        for (int i = 0; i < N; i++) begin
            nodes_x[i*32 +: 32] = 32'(i + 1) * 32'h0001_0000;
            nodes_y[i*32 +: 32] = 32'h0002_0000;
        end
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
        chk("t5.ovr_keep", 32'(overrun_cnt), 32'd1);
        for (int i = 0; i < N; i++) begin
            chk_beat("t5.nf", i, i + 1, 2, 1'b0);
            tick();
        end
        chk("t5.end_valid", 32'(out_valid), 32'd0);

        // 6: reset mid-stream, then a fresh frame
        set_ramp();
        start_frame();
        tick();
        tick();
        chk_beat("t6.b2", 2, 20, 20, 1'b0);
        reset = 1'b0;
        tick();
        chk("t6.valid", 32'(out_valid), 32'd0);
        chk("t6.busy",  32'(busy), 32'd0);
        chk("t6.ovr",   32'(overrun_cnt), 32'd0);
        chk("t6.px",    32'(out_px), 32'd0);
        reset = 1'b1;
        tick();
        chk("t6.idle", 32'(out_valid), 32'd0);
        start_frame();
        for (int i = 0; i < N; i++) begin
            chk_beat("t6.fresh", i, i * 10, 20, 1'b0);
            tick();
        end
        chk("t6.end_valid", 32'(out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
